// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store unit size encodings, FSM state type and lane helpers
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    WAIT_GNT    = 2'b01,
    WAIT_RVALID = 2'b10
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return BE_B << off;
      SIZE_H:  return BE_H << off;
      default: return BE_W;
    endcase
  endfunction

  // Clears store bits above the access size so unused lanes drive zero.
  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return 32'h0000_00FF;
      SIZE_H:  return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_rdata_align.sv
// rtl/lsu_rdata_align.sv - load lane extraction with sign or zero extension
module lsu_rdata_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic        sign_b;
  logic        sign_h;

  assign shifted = rdata >> {offset, 3'b000};
  assign sign_b  = ~is_unsigned & shifted[7];
  assign sign_h  = ~is_unsigned & shifted[15];

  always_comb begin
    data = shifted;
    case (size)
      SIZE_B:  data = {{24{sign_b}}, shifted[7:0]};
      SIZE_H:  data = {{16{sign_h}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit between core and data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [1:0]        lsu_size_i,
  input  logic              lsu_unsigned_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  output logic              lsu_busy_o,
  output logic              lsu_rvalid_o,
  output logic [31:0]       lsu_rdata_o,
  output logic              lsu_misalign_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [31:0]       data_wdata_o,
  input  logic [31:0]       data_rdata_i
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [31:0]       wdata_q;
  logic              rvalid_q;
  logic              misalign_q;
  logic [31:0]       rdata_q;
  logic [31:0]       load_data;
  logic              accept;
  logic              reject;
  logic              complete;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    reject   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          if (is_misaligned(lsu_size_i, lsu_addr_i[1:0])) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        if (data_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= SIZE_B;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
    end else if (accept) begin
      addr_q     <= lsu_addr_i;
      we_q       <= lsu_we_i;
      size_q     <= lsu_size_i;
      unsigned_q <= lsu_unsigned_i;
      wdata_q    <= lsu_wdata_i & lane_mask(lsu_size_i);
    end
  end

  // Store completions report zero so the core never sees stale load data as fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rvalid_q   <= complete;
      misalign_q <= reject;
      if (complete) rdata_q <= we_q ? 32'h0 : load_data;
    end
  end

  lsu_rdata_align u_rdata_align (
    .rdata       (data_rdata_i),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .data        (load_data)
  );

  assign data_req_o     = (state_q == WAIT_GNT);
  assign data_addr_o    = {addr_q[ADDR_W-1:2], 2'b00};
  assign data_we_o      = data_req_o & we_q;
  assign data_be_o      = data_req_o ? byte_enables(size_q, addr_q[1:0]) : 4'b0000;
  assign data_wdata_o   = wdata_q << {addr_q[1:0], 3'b000};
  assign lsu_busy_o     = (state_q != IDLE);
  assign lsu_rvalid_o   = rvalid_q;
  assign lsu_rdata_o    = rdata_q;
  assign lsu_misalign_o = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req_i, lsu_we_i, lsu_unsigned_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_busy_o, lsu_rvalid_o, lsu_misalign_o;
  logic [31:0] lsu_rdata_o;
  logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;

  int checks = 0;
  int failures = 0;
  logic [7:0]  mem_b [logic [31:0]];
  logic [31:0] last_rdata;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_unsigned_i(lsu_unsigned_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_busy_o(lsu_busy_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_misalign_o(lsu_misalign_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem_b.exists(a)) return mem_b[a];
    return 8'(a * 37 + 11);
  endfunction

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem_b[a + i] = w[8*i +: 8];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One core request through the whole handshake; expectations come from a byte-addressed memory model.
  task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int gw, input int rw,
                        output logic [3:0] be_got, output logic [31:0] wd_got,
                        output logic [31:0] rd_got, output int req_cyc, output int lat);
    int n;
    logic mis;
    logic [3:0] exp_be;
    logic [31:0] exp_wd, exp_rd, exp_addr, word;
    n = 1 << size;
    mis = (size == 2'b11) || ((addr % n) != 0);
    exp_be = 4'b0; exp_wd = 32'h0; exp_rd = 32'h0; word = 32'h0;
    exp_addr = {addr[31:2], 2'b00};
    for (int i = 0; i < 4; i++) word[8*i +: 8] = rd_byte(exp_addr + i);
    if (!mis) begin
      for (int i = 0; i < n; i++) begin
        exp_be[addr[1:0] + i] = 1'b1;
        exp_wd[8*(addr[1:0] + i) +: 8] = wdata[8*i +: 8];
        exp_rd[8*i +: 8] = rd_byte(addr + i);
      end
      if (!uns && n < 4 && exp_rd[8*n-1])
        for (int j = 8 * n; j < 32; j++) exp_rd[j] = 1'b1;
      if (we) exp_rd = 32'h0;
    end
    be_got = 4'b0; wd_got = 32'h0; rd_got = 32'h0; req_cyc = 0; lat = 0;

    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_unsigned_i = uns;
    lsu_addr_i = addr; lsu_wdata_i = wdata;
    step(); lat = 1;
    lsu_req_i = 1'b0;

    if (mis) begin
      checks++;
      if (lsu_misalign_o !== 1'b1 || data_req_o !== 1'b0 || lsu_busy_o !== 1'b0) begin
        failures++;
        $display("FAIL misalign_pulse addr=%h got mis=%b req=%b busy=%b exp 1 0 0", addr, lsu_misalign_o, data_req_o, lsu_busy_o);
      end
      step();
      checks++;
      if (lsu_misalign_o !== 1'b0 || data_req_o !== 1'b0 || lsu_busy_o !== 1'b0 || lsu_rdata_o !== last_rdata) begin
        failures++;
        $display("FAIL misalign_after got mis=%b req=%b busy=%b rdata=%h exp 0 0 0 %h", lsu_misalign_o, data_req_o, lsu_busy_o, lsu_rdata_o, last_rdata);
      end
      return;
    end

    checks++;
    if (lsu_misalign_o !== 1'b0) begin
      failures++;
      $display("FAIL spurious_misalign got=%b exp=0", lsu_misalign_o);
    end
    be_got = data_be_o;
    wd_got = data_wdata_o;

    for (int k = 0; k <= gw; k++) begin
      checks++;
      if (data_req_o !== 1'b1 || lsu_busy_o !== 1'b1 || data_addr_o !== exp_addr || data_be_o !== exp_be ||
          data_we_o !== we || data_wdata_o !== exp_wd) begin
        failures++;
        $display("FAIL req_phase k=%0d got req=%b busy=%b addr=%h be=%b we=%b wd=%h exp 1 1 %h %b %b %h",
                 k, data_req_o, lsu_busy_o, data_addr_o, data_be_o, data_we_o, data_wdata_o, exp_addr, exp_be, we, exp_wd);
      end
      if (data_req_o === 1'b1) req_cyc++;
      data_gnt_i = (k == gw);
      data_rvalid_i = (k < gw) ? 1'($urandom % 2) : 1'b0;
      data_rdata_i = $urandom;
      lsu_req_i = 1'($urandom % 2); lsu_addr_i = $urandom; lsu_we_i = ~we;
      step(); lat++;
    end
    data_gnt_i = 1'b0;

    for (int k = 0; k <= rw; k++) begin
      checks++;
      if (data_req_o !== 1'b0 || lsu_busy_o !== 1'b1 || lsu_rvalid_o !== 1'b0) begin
        failures++;
        $display("FAIL rvalid_wait k=%0d got req=%b busy=%b rvalid=%b exp 0 1 0", k, data_req_o, lsu_busy_o, lsu_rvalid_o);
      end
      data_rvalid_i = (k == rw);
      data_gnt_i = (k < rw) ? 1'($urandom % 2) : 1'b0;
      data_rdata_i = (k == rw) ? word : $urandom;
      lsu_req_i = 1'($urandom % 2); lsu_addr_i = $urandom;
      step(); lat++;
    end
    lsu_req_i = 1'b0; data_rvalid_i = 1'b0; data_gnt_i = 1'b0;

    rd_got = lsu_rdata_o;
    checks++;
    if (lsu_rvalid_o !== 1'b1 || lsu_busy_o !== 1'b0 || data_req_o !== 1'b0 || lsu_rdata_o !== exp_rd) begin
      failures++;
      $display("FAIL completion addr=%h we=%b size=%0d got rvalid=%b busy=%b req=%b rdata=%h exp 1 0 0 %h",
               addr, we, size, lsu_rvalid_o, lsu_busy_o, data_req_o, lsu_rdata_o, exp_rd);
    end
    if (we) for (int i = 0; i < n; i++) mem_b[addr + i] = wdata[8*i +: 8];
    last_rdata = exp_rd;
    step();
    checks++;
    if (lsu_rvalid_o !== 1'b0 || lsu_rdata_o !== last_rdata) begin
      failures++;
      $display("FAIL rdata_hold got rvalid=%b rdata=%h exp 0 %h", lsu_rvalid_o, lsu_rdata_o, last_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lsu_req_i = 0; lsu_we_i = 0; lsu_size_i = 0; lsu_unsigned_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
    last_rdata = 32'h0;
    #2;
    checks++;
    if ({lsu_busy_o, lsu_rvalid_o, lsu_misalign_o, data_req_o, data_we_o, data_be_o} !== 9'b0 ||
        lsu_rdata_o !== 32'h0 || data_addr_o !== 32'h0 || data_wdata_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b rv=%b mis=%b req=%b we=%b be=%b rdata=%h addr=%h wd=%h exp all 0",
               lsu_busy_o, lsu_rvalid_o, lsu_misalign_o, data_req_o, data_we_o, data_be_o, lsu_rdata_o, data_addr_o, data_wdata_o);
    end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [3:0] be; logic [31:0] wd, rd; int rc, lat;
    put_word(32'h1000, 32'h1280_5634);
    run_op(1'b0, 2'b00, 1'b0, 32'h1002, 32'h0, 0, 0, be, wd, rd, rc, lat);
    checks++;
    if (be !== 4'b0100 || rd !== 32'hFFFF_FF80 || lat !== 3) begin
      failures++;
      $display("FAIL lb_1002 got be=%b rdata=%h lat=%0d exp 0100 ffffff80 3", be, rd, lat);
    end
    put_word(32'h1000, 32'h8001_5678);
    run_op(1'b0, 2'b01, 1'b1, 32'h1002, 32'h0, 1, 2, be, wd, rd, rc, lat);
    checks++;
    if (rd !== 32'h0000_8001) begin
      failures++;
      $display("FAIL lhu_1002 got=%h exp=00008001", rd);
    end
    run_op(1'b0, 2'b01, 1'b0, 32'h1002, 32'h0, 0, 1, be, wd, rd, rc, lat);
    checks++;
    if (rd !== 32'hFFFF_8001) begin
      failures++;
      $display("FAIL lh_1002 got=%h exp=ffff8001", rd);
    end
    run_op(1'b1, 2'b00, 1'b0, 32'h2001, 32'h0000_00AB, 3, 0, be, wd, rd, rc, lat);
    checks++;
    if (rc !== 4 || be !== 4'b0010 || wd !== 32'h0000_AB00) begin
      failures++;
      $display("FAIL sb_2001 got req_cycles=%0d be=%b wd=%h exp 4 0010 0000ab00", rc, be, wd);
    end
    run_op(1'b0, 2'b10, 1'b0, 32'h3002, 32'h0, 0, 0, be, wd, rd, rc, lat);
  endtask

  task automatic test_reset_mid_access();
    logic [3:0] be; logic [31:0] wd, rd; int rc, lat;
    put_word(32'h0, 32'hCAFE_F00D);
    lsu_req_i = 1; lsu_we_i = 0; lsu_size_i = 2'b10; lsu_unsigned_i = 0; lsu_addr_i = 32'h0;
    step();
    lsu_req_i = 0; data_gnt_i = 1;
    step();
    data_gnt_i = 0;
    rst = 1'b1;
    #1;
    checks++;
    if ({lsu_busy_o, lsu_rvalid_o, data_req_o, data_be_o} !== 7'b0 || lsu_rdata_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b rv=%b req=%b be=%b rdata=%h exp all 0", lsu_busy_o, lsu_rvalid_o, data_req_o, data_be_o, lsu_rdata_o);
    end
    step(); step();
    rst = 1'b0;
    last_rdata = 32'h0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_AAAA;
    step();
    data_rvalid_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (lsu_rvalid_o !== 1'b0 || lsu_busy_o !== 1'b0 || lsu_rdata_o !== 32'h0) begin
        failures++;
        $display("FAIL late_rvalid k=%0d got rv=%b busy=%b rdata=%h exp 0 0 0", k, lsu_rvalid_o, lsu_busy_o, lsu_rdata_o);
      end
      step();
    end
    run_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, 0, be, wd, rd, rc, lat);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL lw_after_reset got=%h exp=cafef00d", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] be; logic [31:0] wd, rd; int rc, lat;
    run_op(1'b1, 2'b10, 1'b0, 32'h4000, 32'hDEAD_BEEF, 0, 0, be, wd, rd, rc, lat);
    checks++;
    if (be !== 4'b1111 || wd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL sw_4000 got be=%b wd=%h exp 1111 deadbeef", be, wd);
    end
    run_op(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 0, 0, be, wd, rd, rc, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL lw_4000 got=%h exp=deadbeef", rd);
    end
  endtask

  task automatic test_random();
    logic [3:0] be; logic [31:0] wd, rd; int rc, lat;
    logic [1:0] size; logic [31:0] addr;
    for (int it = 0; it < 80; it++) begin
      size = ($urandom % 10 == 0) ? 2'b11 : 2'($urandom % 3);
      addr = 32'h5000 + ($urandom % 32);
      if ($urandom % 4 != 0 && size != 2'b11) addr = addr & ~((32'h1 << size) - 1);
      run_op(1'($urandom % 2), size, 1'($urandom % 2), addr, $urandom,
             int'($urandom % 3), int'($urandom % 3), be, wd, rd, rc, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, 32, width of core and data-memory address buses.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 lsu_req_i  input  1  core requests one load/store; sampled only in IDLE.
REQ-005 lsu_we_i  input  1  1 = store, 0 = load.
REQ-006 lsu_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 lsu_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0.
REQ-008 lsu_addr_i  input  ADDR_W  byte address.
REQ-009 lsu_wdata_i  input  32  store data, right-justified.
REQ-010 lsu_busy_o  output  1  high whenever state is not IDLE; core stalls on it.
REQ-011 lsu_rvalid_o  output  1  one-cycle pulse: access completed.
REQ-012 lsu_rdata_o  output  32  extended load data; valid with lsu_rvalid_o.
REQ-013 lsu_misalign_o  output  1  one-cycle pulse: request rejected.
REQ-014 data_req_o  output  1  request to data memory.
REQ-015 data_gnt_i  input  1  memory accepted the request.
REQ-016 data_rvalid_i  input  1  memory response valid (loads and stores).
REQ-017 data_addr_o  output  ADDR_W  word-aligned address (bits [1:0] = 0).
REQ-018 data_we_o  output  1  write enable.
REQ-019 data_be_o  output  4  byte enables.
REQ-020 data_wdata_o  output  32  lane-shifted store data.
REQ-021 data_rdata_i  input  32  raw read word.

Function
REQ-022 FSM states: IDLE, WAIT_GNT, WAIT_RVALID. The FSM is the only sequential state besides the request, output and misalign registers.
REQ-023 IDLE, lsu_req_i=1, aligned and legal: latch addr/we/size/unsigned/wdata; next state WAIT_GNT.
REQ-024 Misaligned (half with addr[0]=1; word with addr[1:0]!=0; size 11): no memory access; lsu_misalign_o pulses the next cycle; FSM stays IDLE.
REQ-025 WAIT_GNT: data_req_o=1 and the address/we/be/wdata outputs are held stable until an edge with data_gnt_i=1; then next state is WAIT_RVALID and data_req_o=0.
REQ-026 WAIT_RVALID: on an edge with data_rvalid_i=1, register the extended rdata (zero for stores), pulse lsu_rvalid_o the next cycle, and return to IDLE.
REQ-027 Minimum latency: accept edge T; data_req_o high in cycle T+1; with gnt in T+1 and rvalid in T+2, lsu_rvalid_o is high in T+3.
REQ-028 Byte enables: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
REQ-029 Store data is shifted left by 8*addr[1:0]; unused lanes are 0.
REQ-030 Load: shift data_rdata_i right by 8*addr[1:0], take 8, 16 or 32 bits, then sign- or zero-extend to 32.
REQ-031 lsu_req_i while busy is ignored.
REQ-032 data_rvalid_i in IDLE or WAIT_GNT and data_gnt_i outside WAIT_GNT are ignored.
REQ-033 lsu_rdata_o holds its last value until the next completion.

Reset
REQ-034 rst=1 immediately forces IDLE; all outputs are 0, including data_req_o and data_be_o.
REQ-035 Reset during WAIT_GNT or WAIT_RVALID abandons the access; any rvalid arriving after release is ignored and produces no lsu_rvalid_o.

Structure
REQ-036 Package lsu_pkg holds the size encodings (SIZE_B, SIZE_H, SIZE_W), the FSM state type and the byte-enable constants.
REQ-037 One combinational sub-module, lsu_rdata_align, performs the load lane extraction and extension; the FSM and registers stay in load_store_unit.

Verification
REQ-038 lb at 0x1002, rdata 0x12805634, gnt and rvalid with zero wait -> be=0100, lsu_rdata_o=0xFFFFFF80, lsu_rvalid_o at T+3.
REQ-039 lhu at 0x1002, rdata 0x80015678 -> lsu_rdata_o=0x00008001; lh of the same word and address -> 0xFFFF8001.
REQ-040 sb at 0x2001, wdata 0x000000AB, gnt delayed 3 cycles -> data_req_o high 4 cycles, addr 0x2000, be=0010, wdata=0x0000AB00, busy until lsu_rvalid_o.
REQ-041 lw at 0x3002 -> lsu_misalign_o pulses once, data_req_o never rises, busy stays 0.
REQ-042 Reset asserted in WAIT_RVALID, then a late rvalid after release -> outputs 0, no lsu_rvalid_o, next lw at 0x0 completes normally.
REQ-043 Back-to-back sw 0x4000 (0xDEADBEEF) then lw 0x4000 against a memory model -> be=1111 and lsu_rdata_o=0xDEADBEEF.
